int_ctrl: RTL and testbench
===========================

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter BASE, default 32'h00007f20, word-aligned base address of the 16-byte register window.
REQ-002 Parameter NSRC, default 6, number of interrupt sources; fixed to 6 in this revision.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 addr  input  32  bridge byte address; block selected when addr[31:4] == BASE[31:4].
REQ-006 we  input  1  bridge write enable, qualified by select.
REQ-007 wd  input  32  bridge write data.
REQ-008 rd  output  32  combinational read data for selected offset addr[3:2].
REQ-009 irq_in  input  6  raw device interrupt lines (timer0 = bit 0, timer1 = bit 1, others spare).
REQ-010 int_ack  input  1  one-cycle pulse from CPU/CP0 when the interrupt exception is taken.
REQ-011 hwint  output  6  registered one-hot request to CP0 hwint inputs.
REQ-012 irq_id  output  3  registered index of the granted/in-service source; 3'd7 when none.

Function
REQ-013 The block SHALL map registers: 0x0 MASK (rw, bits[5:0]), 0x4 PEND (r; write-1-to-clear), 0x8 MODE (rw, 1 = edge, 0 = level), 0xC ISR (read {29'b0, irq_id}; any write = EOI).
REQ-014 The block SHALL read unused bits as 0.
REQ-015 The block SHALL, for a level source, load PEND[i] <= irq_in[i] every cycle; W1C SHALL have no lasting effect on level sources.
REQ-016 The block SHALL, for an edge source, set PEND[i] on a registered 0->1 transition of irq_in[i]; set SHALL win over W1C or ack-clear in the same cycle.
REQ-017 The block SHALL compute eligible = PEND & MASK; the lowest index eligible source has the highest priority.
REQ-018 The FSM SHALL have states IDLE, REQ and SERV.
REQ-019 IDLE -> REQ when eligible != 0, latching irq_id = winner; hwint = one-hot(winner) from the next cycle (1-cycle latency).
REQ-020 In REQ, if the latched source leaves eligible before ack (level drop, mask clear or W1C), the FSM SHALL return to IDLE with hwint = 0 and irq_id = 7.
REQ-021 In REQ, a higher-priority source becoming eligible SHALL replace irq_id and hwint on the next cycle; the FSM SHALL stay in REQ.
REQ-022 REQ -> SERV on int_ack: hwint <= 0; irq_id is held; PEND[irq_id] is cleared if that source is edge-mode.
REQ-023 SERV -> IDLE on an EOI write: irq_id <= 7; no nesting, so hwint SHALL stay 0 throughout SERV.
REQ-024 int_ack outside REQ and EOI outside SERV SHALL be ignored.
REQ-025 Register writes SHALL take effect on the clock edge of the write; a MASK write SHALL affect arbitration in the following cycle.

Reset
REQ-026 On reset, MASK, PEND, MODE and the edge-detect history register SHALL be 0, FSM = IDLE, hwint = 0 and irq_id = 7.
REQ-027 Reset asserted mid-REQ or mid-SERV SHALL abandon the service with no EOI required.

Configuration
REQ-028 Macro INT_CTRL_EDGE_EN defined: MODE register and edge detection SHALL be present.
REQ-029 INT_CTRL_EDGE_EN undefined: MODE SHALL read 0 and ignore writes, all sources SHALL be level, and no edge-history flops SHALL exist.

Structure
REQ-030 Register offsets, FSM state encoding and IRQ_NONE = 3'd7 SHALL live in the shared package/header alongside the existing CPU defines.
REQ-031 Priority encoding SHALL be one sub-module, int_prio_enc (6-bit vector in, 3-bit index plus valid out).

Verification
REQ-032 MASK = 6'h03, level irq_in[1] = 1 -> hwint = 6'b000010 and irq_id = 1 two cycles later; int_ack -> hwint = 0, ISR reads 1; EOI -> irq_id = 7.
REQ-033 irq_in = 6'b000110 simultaneously, MASK = 6'h3F -> irq_id = 1; after ack + EOI with bit 1 deasserted, the FSM re-enters REQ with irq_id = 2.
REQ-034 Edge mode (MODE = 6'h01), 1-cycle pulse on irq_in[0] -> PEND = 1 persists after the pulse; ack clears PEND; a new edge in the same ack cycle leaves PEND = 1.
REQ-035 In REQ with level irq_in[1], write MASK = 0 -> hwint = 0 and irq_id = 7 the next cycle, FSM in IDLE; int_ack then has no effect.
REQ-036 Reset asserted in SERV -> all registers 0 and irq_id = 7; a read at BASE+0x8 with INT_CTRL_EDGE_EN undefined after writing 6'h3F returns 0.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// FSM state encoding, the "no source" index and a one-hot helper.
package int_ctrl_pkg;

    localparam int unsigned NSRC_W = 6;
    localparam int unsigned IDX_W  = 3;

    // Word offsets within the 16-byte window (addr[3:2])
    localparam logic [1:0] OFF_MASK = 2'd0;
    localparam logic [1:0] OFF_PEND = 2'd1;
    localparam logic [1:0] OFF_MODE = 2'd2;
    localparam logic [1:0] OFF_ISR  = 2'd3;

    localparam logic [IDX_W-1:0] IRQ_NONE = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } state_t;

    // One-hot decode of a source index; out-of-range indices give all zeros
    function automatic logic [NSRC_W-1:0] onehot(input logic [IDX_W-1:0] id);
        logic [NSRC_W-1:0] v;
        v = '0;
        for (int i = 0; i < int'(NSRC_W); i++) begin
            if (id == IDX_W'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set bit wins.
module int_prio_enc
    import int_ctrl_pkg::*;
(
    input  logic [NSRC_W-1:0] i_vec,
    output logic [IDX_W-1:0]  o_idx_c,
    output logic              o_valid_c
);

    // Scan from the top so the lowest set index is the last assignment
    always_comb begin
        o_idx_c   = IRQ_NONE;
        o_valid_c = |i_vec;
        for (int i = int'(NSRC_W) - 1; i >= 0; i--) begin
            if (i_vec[i]) o_idx_c = IDX_W'(i);
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: MASK/PEND/MODE/ISR register window, priority
// arbitration and a request/service handshake towards CP0.
// Optional feature macro: INT_CTRL_EDGE_EN (MODE register + edge detection).
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE = 32'h00007f20,
    parameter int unsigned NSRC = 6
)(
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     addr,
    input  logic            we,
    input  logic [31:0]     wd,
    output logic [31:0]     rd,
    input  logic [NSRC-1:0] irq_in,
    input  logic            int_ack,
    output logic [NSRC-1:0] hwint,
    output logic [2:0]      irq_id
);

    logic [NSRC_W-1:0] r_mask;
    logic [NSRC_W-1:0] r_pend;
    logic [NSRC_W-1:0] r_hwint;
    logic [IDX_W-1:0]  r_irq_id;
    state_t            r_state;

    logic              w_sel;
    logic              w_wr_mask;
    logic              w_wr_pend;
    logic              w_wr_mode;
    logic              w_eoi;
    logic [NSRC_W-1:0] w_mode;
    logic [NSRC_W-1:0] w_pend_nxt;
    logic [NSRC_W-1:0] w_elig;
    logic [IDX_W-1:0]  w_win;
    logic              w_win_vld;
    logic              w_cur_elig;
    state_t            w_state_nxt;
    logic [NSRC_W-1:0] w_hwint_nxt;
    logic [IDX_W-1:0]  w_irq_id_nxt;
    logic              w_unused;

    assign w_unused = ^{addr[1:0], wd[31:NSRC_W], w_wr_mode};

    // Bridge decode
    assign w_sel     = (addr[31:4] == BASE[31:4]);
    assign w_wr_mask = w_sel && we && (addr[3:2] == OFF_MASK);
    assign w_wr_pend = w_sel && we && (addr[3:2] == OFF_PEND);
    assign w_wr_mode = w_sel && we && (addr[3:2] == OFF_MODE);
    assign w_eoi     = w_sel && we && (addr[3:2] == OFF_ISR);

`ifdef INT_CTRL_EDGE_EN
    logic [NSRC_W-1:0] r_mode;
    logic [NSRC_W-1:0] r_hist;
    logic [NSRC_W-1:0] w_rise;
    logic [NSRC_W-1:0] w_w1c;
    logic [NSRC_W-1:0] w_ack_clr;

    assign w_mode    = r_mode;
    assign w_rise    = irq_in & ~r_hist;
    assign w_w1c     = w_wr_pend ? wd[NSRC_W-1:0] : '0;
    assign w_ack_clr = (r_state == ST_REQ && int_ack) ? onehot(r_irq_id) : '0;
    // Edge sources: set wins over W1C/ack clear; level sources follow the pin
    assign w_pend_nxt = (w_mode & (w_rise | (r_pend & ~(w_w1c | w_ack_clr))))
                      | (~w_mode & irq_in);

    // MODE register and edge history
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode <= '0;
            r_hist <= '0;
        end else begin
            r_hist <= irq_in;
            if (w_wr_mode) r_mode <= wd[NSRC_W-1:0];
        end
    end
`else
    assign w_mode     = '0;
    // All sources are level: PEND simply tracks the pins, W1C has no effect
    assign w_pend_nxt = irq_in & ~w_unused_w1c_gate();
    function automatic logic [NSRC_W-1:0] w_unused_w1c_gate();
        return (w_wr_pend && 1'b0) ? '1 : '0;
    endfunction
`endif

    // MASK and PEND registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_wr_mask) r_mask <= wd[NSRC_W-1:0];
        end
    end

    assign w_elig = r_pend & r_mask;

    int_prio_enc u_prio (
        .i_vec     (w_elig),
        .o_idx_c   (w_win),
        .o_valid_c (w_win_vld)
    );

    assign w_cur_elig = |(w_elig & onehot(r_irq_id));

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_hwint  <= '0;
            r_irq_id <= IRQ_NONE;
        end else begin
            r_state  <= w_state_nxt;
            r_hwint  <= w_hwint_nxt;
            r_irq_id <= w_irq_id_nxt;
        end
    end

    // FSM next-state and next-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_hwint_nxt  = r_hwint;
        w_irq_id_nxt = r_irq_id;
        case (r_state)
            ST_IDLE: begin
                w_hwint_nxt  = '0;
                w_irq_id_nxt = IRQ_NONE;
                if (w_win_vld) begin
                    w_state_nxt  = ST_REQ;
                    w_hwint_nxt  = onehot(w_win);
                    w_irq_id_nxt = w_win;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    w_state_nxt = ST_SERV;
                    w_hwint_nxt = '0;
                end else if (!w_cur_elig) begin
                    w_state_nxt  = ST_IDLE;
                    w_hwint_nxt  = '0;
                    w_irq_id_nxt = IRQ_NONE;
                end else if (w_win != r_irq_id) begin
                    w_hwint_nxt  = onehot(w_win);
                    w_irq_id_nxt = w_win;
                end
            end
            ST_SERV: begin
                w_hwint_nxt = '0;
                if (w_eoi) begin
                    w_state_nxt  = ST_IDLE;
                    w_irq_id_nxt = IRQ_NONE;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_hwint_nxt  = '0;
                w_irq_id_nxt = IRQ_NONE;
            end
        endcase
    end

    // Combinational read mux; unselected or unused bits read 0
    always_comb begin
        rd = '0;
        if (w_sel) begin
            case (addr[3:2])
                OFF_MASK: rd = 32'(r_mask);
                OFF_PEND: rd = 32'(r_pend);
                OFF_MODE: rd = 32'(w_mode);
                default:  rd = 32'(r_irq_id);
            endcase
        end
    end

    assign hwint  = r_hwint;
    assign irq_id = r_irq_id;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl.
module tb_int_ctrl;

    localparam logic [31:0] BASE = 32'h00007f20;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [5:0]  irq_in;
    logic        int_ack;
    logic [5:0]  hwint;
    logic [2:0]  irq_id;

    int n_chk  = 0;
    int n_pass = 0;

    int_ctrl #(.BASE(BASE), .NSRC(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .we      (we),
        .wd      (wd),
        .rd      (rd),
        .irq_in  (irq_in),
        .int_ack (int_ack),
        .hwint   (hwint),
        .irq_id  (irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] data);
        addr = BASE + 32'(off);
        wd   = data;
        we   = 1'b1;
        step();
        we   = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [3:0] off, input logic [31:0] exp);
        addr = BASE + 32'(off);
        #1;
        chk(tag, rd, exp);
    endtask

    initial begin
        reset = 1'b1; addr = '0; we = 1'b0; wd = '0; irq_in = '0; int_ack = 1'b0;
        step(3);
        reset = 1'b0;

        // Reset state
        chk("rst_hwint", 32'(hwint), 32'h0);
        chk("rst_irq_id", 32'(irq_id), 32'h7);
        rdchk("rst_mask", 4'h0, 32'h0);
        rdchk("rst_pend", 4'h4, 32'h0);
        rdchk("rst_mode", 4'h8, 32'h0);
        rdchk("rst_isr", 4'hC, 32'h7);
        addr = 32'h0000_0000; #1;
        chk("unsel_rd", rd, 32'h0);

        // Basic level request, ack and EOI
        wr(4'h0, 32'h03);
        irq_in = 6'b000010;
        step();
        chk("lvl_lat1_hwint", 32'(hwint), 32'h0);
        step();
        chk("lvl_hwint", 32'(hwint), 32'h02);
        chk("lvl_irq_id", 32'(irq_id), 32'h1);
        rdchk("lvl_pend", 4'h4, 32'h02);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        chk("ack_hwint", 32'(hwint), 32'h0);
        chk("ack_irq_id", 32'(irq_id), 32'h1);
        rdchk("ack_isr", 4'hC, 32'h1);
        irq_in = 6'b000000;
        step(2);
        chk("serv_hwint", 32'(hwint), 32'h0);
        wr(4'hC, 32'h0);
        chk("eoi_irq_id", 32'(irq_id), 32'h7);
        step();
        chk("idle_irq_id", 32'(irq_id), 32'h7);
        chk("idle_hwint", 32'(hwint), 32'h0);

        // Simultaneous sources, priority, re-entry after EOI
        wr(4'h0, 32'h3F);
        irq_in = 6'b000110;
        step(2);
        chk("prio_irq_id", 32'(irq_id), 32'h1);
        chk("prio_hwint", 32'(hwint), 32'h02);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        irq_in = 6'b000100;
        step();
        wr(4'hC, 32'h0);
        chk("prio_eoi_id", 32'(irq_id), 32'h7);
        step();
        chk("reent_irq_id", 32'(irq_id), 32'h2);
        chk("reent_hwint", 32'(hwint), 32'h04);

        // Higher-priority source preempts while in REQ
        irq_in = 6'b000101;
        step(2);
        chk("preempt_irq_id", 32'(irq_id), 32'h0);
        chk("preempt_hwint", 32'(hwint), 32'h01);

        // Level drop in REQ returns to IDLE
        irq_in = 6'b000000;
        step(2);
        chk("drop_irq_id", 32'(irq_id), 32'h7);
        chk("drop_hwint", 32'(hwint), 32'h0);

        // Mask clear in REQ, then ignored ack
        irq_in = 6'b000010;
        step(2);
        chk("mreq_irq_id", 32'(irq_id), 32'h1);
        wr(4'h0, 32'h0);
        chk("mclr_same_edge_hwint", 32'(hwint), 32'h02);
        step();
        chk("mclr_hwint", 32'(hwint), 32'h0);
        chk("mclr_irq_id", 32'(irq_id), 32'h7);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        chk("stray_ack_hwint", 32'(hwint), 32'h0);
        chk("stray_ack_id", 32'(irq_id), 32'h7);
        wr(4'h0, 32'h3F);
        step();
        chk("remask_irq_id", 32'(irq_id), 32'h1);
        chk("remask_hwint", 32'(hwint), 32'h02);
        wr(4'h4, 32'h3F);
        rdchk("lvl_w1c_pend", 4'h4, 32'h02);
        chk("lvl_w1c_id", 32'(irq_id), 32'h1);

        // Reset in SERV abandons service
        int_ack = 1'b1; step(); int_ack = 1'b0;
        chk("pre_rst_serv_id", 32'(irq_id), 32'h1);
        reset = 1'b1; step(); reset = 1'b0;
        irq_in = 6'b000000;
        chk("srst_hwint", 32'(hwint), 32'h0);
        chk("srst_irq_id", 32'(irq_id), 32'h7);
        rdchk("srst_mask", 4'h0, 32'h0);
        rdchk("srst_pend", 4'h4, 32'h0);
        wr(4'h8, 32'h3F);
`ifdef INT_CTRL_EDGE_EN
        rdchk("mode_rd", 4'h8, 32'h3F);

        // Edge mode: pulse latches, ack clears, set beats ack-clear
        wr(4'h8, 32'h01);
        wr(4'h0, 32'h01);
        irq_in = 6'b000001; step(); irq_in = 6'b000000;
        rdchk("edge_pend_set", 4'h4, 32'h01);
        step();
        chk("edge_irq_id", 32'(irq_id), 32'h0);
        step();
        rdchk("edge_pend_hold", 4'h4, 32'h01);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        rdchk("edge_ack_clr", 4'h4, 32'h0);
        chk("edge_ack_hwint", 32'(hwint), 32'h0);
        wr(4'hC, 32'h0);
        irq_in = 6'b000001; step(); irq_in = 6'b000000;
        step();
        chk("edge2_irq_id", 32'(irq_id), 32'h0);
        int_ack = 1'b1; irq_in = 6'b000001; step();
        int_ack = 1'b0; irq_in = 6'b000000;
        rdchk("edge_set_wins", 4'h4, 32'h01);
        chk("edge_set_wins_hwint", 32'(hwint), 32'h0);
        wr(4'hC, 32'h0);
        step();
        chk("edge3_irq_id", 32'(irq_id), 32'h0);
        wr(4'h4, 32'h01);
        rdchk("edge_w1c", 4'h4, 32'h0);
        step();
        chk("edge_w1c_idle", 32'(irq_id), 32'h7);
`else
        rdchk("mode_rd_zero", 4'h8, 32'h0);

        // Without edge support a pulse behaves as level
        wr(4'h0, 32'h01);
        irq_in = 6'b000001; step(); irq_in = 6'b000000;
        rdchk("pulse_pend", 4'h4, 32'h01);
        step();
        rdchk("pulse_pend_gone", 4'h4, 32'h0);
        chk("pulse_irq_id", 32'(irq_id), 32'h0);
        step();
        chk("pulse_idle_id", 32'(irq_id), 32'h7);
        chk("pulse_idle_hwint", 32'(hwint), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
